// File: rtl/stepper_pulse_dispatcher_if.sv
// Command handshake between the pulse-number multiplier and the dispatcher.
// The master issues signed per-axis counts and a pen position under trigger/rdy/done.
interface stepper_pulse_dispatcher_if #(
   parameter int PULSE_NUM_X_BITS = 16,
   parameter int PULSE_NUM_Y_BITS = 16
);
   logic [PULSE_NUM_X_BITS-1:0] pulse_num_x;
   logic [PULSE_NUM_Y_BITS-1:0] pulse_num_y;
   logic                        servo_pos;
   logic                        trigger;
   logic                        rdy;
   logic                        done;

   modport master (
      output pulse_num_x, pulse_num_y, servo_pos, trigger,
      input  rdy, done
   );

   modport slave (
      input  pulse_num_x, pulse_num_y, servo_pos, trigger,
      output rdy, done
   );
endinterface

// File: rtl/stepper_pulse_dispatcher.sv
// Turns one signed X/Y pulse command plus pen position into step/dir trains.
// Both axes share one period counter; servo moves settle before stepping.
module stepper_pulse_dispatcher #(
   parameter int PULSE_NUM_X_BITS = 16,
   parameter int PULSE_NUM_Y_BITS = 16,
   parameter int PULSE_PERIOD     = 1000,
   parameter int PULSE_HIGH       = 500,
   parameter int SERVO_SETTLE     = 50000
) (
   input  logic clk,
   input  logic reset,
   stepper_pulse_dispatcher_if.slave cmd,
   output logic step_x,
   output logic dir_x,
   output logic step_y,
   output logic dir_y,
   output logic servo_out
);
   localparam int XB = PULSE_NUM_X_BITS;
   localparam int YB = PULSE_NUM_Y_BITS;
   localparam int PW = $clog2(PULSE_PERIOD);
   localparam int WW = $clog2(SERVO_SETTLE + 1);

   typedef enum logic [1:0] {
      IDLE,
      SERVO_WAIT,
      STEPPING,
      DONE
   } state_t;

   state_t        state;
   logic [XB-1:0] rem_x;
   logic [YB-1:0] rem_y;
   logic [XB-1:0] mag_x;
   logic [YB-1:0] mag_y;
   logic [PW-1:0] pcnt;
   logic [WW-1:0] wcnt;
   logic          last_slot;
   logic          high_slot;

   // Magnitude keeps input width: -2^(N-1) maps to 2^(N-1) unsigned.
   always_comb begin
      mag_x = cmd.pulse_num_x;
      mag_y = cmd.pulse_num_y;
      if (cmd.pulse_num_x[XB-1]) mag_x = -cmd.pulse_num_x;
      if (cmd.pulse_num_y[YB-1]) mag_y = -cmd.pulse_num_y;
   end

   assign last_slot = (pcnt == PW'(PULSE_PERIOD - 1));
   assign high_slot = (pcnt < PW'(PULSE_HIGH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cmd.rdy   <= 1'b1;
         cmd.done  <= 1'b0;
         step_x    <= 1'b0;
         step_y    <= 1'b0;
         dir_x     <= 1'b0;
         dir_y     <= 1'b0;
         servo_out <= 1'b0;
         rem_x     <= '0;
         rem_y     <= '0;
         pcnt      <= '0;
         wcnt      <= '0;
      end else begin
         cmd.done <= 1'b0;
         step_x   <= 1'b0;
         step_y   <= 1'b0;
         unique case (state)
            IDLE: begin
               cmd.rdy <= 1'b1;
               if (cmd.trigger) begin
                  rem_x     <= mag_x;
                  rem_y     <= mag_y;
                  dir_x     <= cmd.pulse_num_x[XB-1];
                  dir_y     <= cmd.pulse_num_y[YB-1];
                  servo_out <= cmd.servo_pos;
                  cmd.rdy   <= 1'b0;
                  pcnt      <= '0;
                  wcnt      <= '0;
                  if (cmd.servo_pos != servo_out) state <= SERVO_WAIT;
                  else state <= STEPPING;
               end
            end
            SERVO_WAIT: begin
               if (wcnt == WW'(SERVO_SETTLE - 1)) begin
                  state <= STEPPING;
                  pcnt  <= '0;
               end else begin
                  wcnt <= wcnt + WW'(1);
               end
            end
            STEPPING: begin
               // Finish is only decided at a period start, so a step is never cut.
               if (pcnt == '0 && rem_x == '0 && rem_y == '0) begin
                  state    <= DONE;
                  cmd.done <= 1'b1;
               end else begin
                  step_x <= (rem_x != '0) && high_slot;
                  step_y <= (rem_y != '0) && high_slot;
                  if (last_slot) begin
                     pcnt <= '0;
                     if (rem_x != '0) rem_x <= rem_x - XB'(1);
                     if (rem_y != '0) rem_y <= rem_y - YB'(1);
                  end else begin
                     pcnt <= pcnt + PW'(1);
                  end
               end
            end
            DONE: begin
               state   <= IDLE;
               cmd.rdy <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stepper_pulse_dispatcher.sv
// Directed bench: a 16-bit and an 8-bit dispatcher with PERIOD=4, HIGH=2, SETTLE=10.
// Step edges and done timing are counted from the cycle after the accept edge.
module tb_stepper_pulse_dispatcher;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   stepper_pulse_dispatcher_if #(16, 16) ia ();
   stepper_pulse_dispatcher_if #(8, 8)   ib ();

   logic sxa, dxa, sya, dya, soa;
   logic sxb, dxb, syb, dyb, sob;

   stepper_pulse_dispatcher #(
      .PULSE_NUM_X_BITS(16), .PULSE_NUM_Y_BITS(16),
      .PULSE_PERIOD(4), .PULSE_HIGH(2), .SERVO_SETTLE(10)
   ) dut_a (
      .clk(clk), .reset(rst_n), .cmd(ia.slave),
      .step_x(sxa), .dir_x(dxa), .step_y(sya), .dir_y(dya),
      .servo_out(soa)
   );

   stepper_pulse_dispatcher #(
      .PULSE_NUM_X_BITS(8), .PULSE_NUM_Y_BITS(8),
      .PULSE_PERIOD(4), .PULSE_HIGH(2), .SERVO_SETTLE(10)
   ) dut_b (
      .clk(clk), .reset(rst_n), .cmd(ib.slave),
      .step_x(sxb), .dir_x(dxb), .step_y(syb), .dir_y(dyb),
      .servo_out(sob)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d",
                tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic issue(input bit b, input int x, input int y, input bit s);
      @(negedge clk);
      if (b) begin
         ib.pulse_num_x = 8'(x);
         ib.pulse_num_y = 8'(y);
         ib.servo_pos   = s;
         ib.trigger     = 1'b1;
      end else begin
         ia.pulse_num_x = 16'(x);
         ia.pulse_num_y = 16'(y);
         ia.servo_pos   = s;
         ia.trigger     = 1'b1;
      end
      @(negedge clk);
      ia.trigger = 1'b0;
      ib.trigger = 1'b0;
   endtask

   // Called at the negedge after the accept edge (c=0); stops at done.
   task automatic run(input bit b, input int max, output int done_c,
                      output int rx, output int ry, output int hx,
                      output int hy, output int first_x);
      logic px, py, sx, sy, d;
      px = 1'b0; py = 1'b0;
      done_c = -1; rx = 0; ry = 0; hx = 0; hy = 0; first_x = -1;
      for (int c = 0; c <= max; c++) begin
         if (c > 0) @(negedge clk);
         sx = b ? sxb : sxa;
         sy = b ? syb : sya;
         d  = b ? ib.done : ia.done;
         if (sx && !px) begin
            rx++;
            if (first_x < 0) first_x = c;
         end
         if (sy && !py) ry++;
         if (sx) hx++;
         if (sy) hy++;
         px = sx; py = sy;
         if (d) begin
            done_c = c;
            ia.trigger = 1'b0;
            ib.trigger = 1'b0;
            break;
         end
      end
   endtask

   int dc, rx, ry, hx, hy, fx;

   initial begin
      ia.pulse_num_x = '0; ia.pulse_num_y = '0;
      ia.servo_pos = 1'b0; ia.trigger = 1'b0;
      ib.pulse_num_x = '0; ib.pulse_num_y = '0;
      ib.servo_pos = 1'b0; ib.trigger = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rdy", {31'd0, ia.rdy}, 1);
      chk("rst_outs", {27'd0, ia.done, sxa, sya, dxa, dya}, 0);
      chk("rst_servo", {31'd0, soa}, 0);
      chk("rst_rdy_b", {31'd0, ib.rdy}, 1);
      rst_n = 1'b1;

      // x=3, y=-5, servo unchanged
      issue(0, 3, -5, 0);
      chk("t1_rdy_low", {31'd0, ia.rdy}, 0);
      chk("t1_dirs", {30'd0, dxa, dya}, 1);
      run(0, 60, dc, rx, ry, hx, hy, fx);
      chk("t1_first_x", fx, 1);
      chk("t1_rx", rx, 3);
      chk("t1_ry", ry, 5);
      chk("t1_hx", hx, 6);
      chk("t1_hy", hy, 10);
      chk("t1_done_c", dc, 21);
      chk("t1_done_rdy", {31'd0, ia.rdy}, 0);
      @(negedge clk);
      chk("t1_rdy_back", {30'd0, ia.rdy, ia.done}, 2);
      chk("t1_dir_hold", {30'd0, dxa, dya}, 1);

      // x=2, y=2, servo 0->1
      issue(0, 2, 2, 1);
      chk("t2_servo", {31'd0, soa}, 1);
      run(0, 60, dc, rx, ry, hx, hy, fx);
      chk("t2_first_x", fx, 11);
      chk("t2_rx", rx, 2);
      chk("t2_ry", ry, 2);
      chk("t2_done_c", dc, 19);
      @(negedge clk);
      chk("t2_single_done", {30'd0, ia.rdy, ia.done}, 2);

      // zero-length command, servo unchanged
      issue(0, 0, 0, 1);
      run(0, 20, dc, rx, ry, hx, hy, fx);
      chk("t3_steps", rx + ry, 0);
      chk("t3_done_c", dc, 1);
      @(negedge clk);
      chk("t3_rdy", {31'd0, ia.rdy}, 1);

      // 8-bit extremes
      issue(1, -128, 127, 0);
      chk("t4_dirs", {30'd0, dxb, dyb}, 2);
      run(1, 600, dc, rx, ry, hx, hy, fx);
      chk("t4_rx", rx, 128);
      chk("t4_ry", ry, 127);
      chk("t4_done_c", dc, 513);
      @(negedge clk);
      chk("t4_rdy", {31'd0, ib.rdy}, 1);

      // trigger held during STEPPING with other values is ignored
      issue(0, 1, 1, 1);
      ia.pulse_num_x = 16'd7;
      ia.pulse_num_y = 16'd7;
      ia.trigger = 1'b1;
      run(0, 40, dc, rx, ry, hx, hy, fx);
      chk("t5_rx", rx, 1);
      chk("t5_ry", ry, 1);
      chk("t5_done_c", dc, 5);
      @(negedge clk);
      chk("t5_rdy", {31'd0, ia.rdy}, 1);
      issue(0, 1, 0, 1);
      run(0, 40, dc, rx, ry, hx, hy, fx);
      chk("t5_new_rx", rx, 1);
      chk("t5_new_ry", ry, 0);
      chk("t5_new_done", dc, 5);

      // reset after 2 of 5 pulses
      issue(0, 5, 5, 1);
      run(0, 8, dc, rx, ry, hx, hy, fx);
      chk("t6_pre_rx", rx, 2);
      chk("t6_pre_done", dc, -1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_rdy", {31'd0, ia.rdy}, 1);
      chk("t6_rst_outs", {26'd0, ia.done, sxa, sya, dxa, dya, soa}, 0);
      repeat (3) begin
         @(negedge clk);
         chk("t6_no_done", {31'd0, ia.done}, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_rdy_after", {31'd0, ia.rdy}, 1);
      issue(0, -2, 1, 0);
      chk("t6_dirs", {30'd0, dxa, dya}, 2);
      run(0, 40, dc, rx, ry, hx, hy, fx);
      chk("t6_rx", rx, 2);
      chk("t6_ry", ry, 1);
      chk("t6_done_c", dc, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
